dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of the shared 512x8 data memory.
REQ-002 Parameter DATA_W, default 32, data width of every port.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
REQ-004 Per-requester ports SHALL be provided for requester 0 (core LSU) and requester 1 (loader), with x = 0 or 1:
- reqx  input  1  request, held high until donex.
- wex  input  1  1 = write, 0 = read.
- addrx  input  ADDR_W  byte address.
- wdatax  input  DATA_W  write data.
- sizex  input  2  00 = byte, 01 = half, 10 or 11 = word.
- sextx  input  1  sign-extend read data.
- donex  output  1  one-cycle completion pulse.
- errx  output  1  bounds error, valid with donex.
- rdatax  output  DATA_W  read data, valid with donex.
REQ-005 Memory-side ports SHALL be provided:
- mem_en  output  1
- mem_rw  output  1
- mem_addr  output  ADDR_W
- mem_din  output  DATA_W
- mem_size  output  2
- mem_sext  output  1
- mem_dout  input  DATA_W

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, STROBE, CAPTURE and ERR.
REQ-007 The FSM SHALL sample requests only in IDLE; on acceptance it SHALL latch we, addr, wdata, size and sext of the granted requester into internal registers.
REQ-008 Arbitration SHALL be round-robin: a single request wins; for simultaneous requests, the requester not granted last wins; the last-grant register SHALL update on every acceptance.
REQ-009 Bounds check at acceptance: end = addr + nbytes - 1, with nbytes = 1, 2 or 4; end > 2^ADDR_W - 1 SHALL transition to ERR and SHALL NOT drive mem_en.
REQ-010 IDLE SHALL go to SETUP on an in-bounds accept. SETUP SHALL drive the mem_* controls with mem_en = 0 and go to STROBE. STROBE SHALL drive mem_en = 1 with controls unchanged and go to CAPTURE. CAPTURE SHALL drive mem_en = 0, register rdata from mem_dout on reads, pulse donex and go to IDLE.
REQ-011 The mem_* address, data and control outputs SHALL remain stable from SETUP through CAPTURE, giving setup and hold around the mem_en rising edge.
REQ-012 Latency: accept at cycle t -> donex at t+3 for a valid access; donex with errx = 1 at t+1 from ERR; no new accept in the cycle donex is high.
REQ-013 mem_rw SHALL equal the latched we; mem_sext SHALL equal the latched sext; size 11 SHALL be forwarded unchanged.
REQ-014 rdatax SHALL hold its last value until the next read completes for that requester; on writes rdatax SHALL be unchanged.
REQ-015 donex and errx SHALL be asserted only toward the granted requester; the other requester's outputs SHALL remain 0.
REQ-016 A request that drops before acceptance SHALL be ignored; a request that drops after acceptance SHALL still complete (no abort).

Reset
REQ-017 On rst, the FSM SHALL enter IDLE and the following SHALL be 0: mem_en, mem_rw, mem_addr, mem_din, mem_size, mem_sext, done0/1, err0/1 and rdata0/1.
REQ-018 On rst, the last-grant register SHALL be set to 1, so requester 0 wins the first contention.
REQ-019 Reset asserted in STROBE or CAPTURE SHALL drop mem_en the next cycle; a write already strobed is not undone, and no donex SHALL be issued.

Structure
REQ-020 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state encoding and the nbytes function.
REQ-021 The two-way round-robin grant SHALL be a sub-module rr_arbiter2 with inputs req[1:0], last and output gnt[1:0].

Verification
REQ-022 Reset, then req0 write of word 0xDEADBEEF to addr 0x010 -> mem_en high exactly at t+2, done0 at t+3, err0 = 0.
REQ-023 Simultaneous req0 and req1 after reset -> requester 0 served first, then requester 1; repeated contention alternates grants.
REQ-024 req1 read of a byte at 0x010 with sext = 1, when memory holds 0xEF -> rdata1 = 0xFFFFFFEF at done1.
REQ-025 req0 word at addr 0x1FE -> done0 and err0 at t+1, with mem_en never asserted.
REQ-026 rst asserted during STROBE -> mem_en = 0 the next cycle, FSM in IDLE, no done pulse.
REQ-027 req0 half-word write 0x1234 to 0x1FE is in bounds -> completes with err0 = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: size codes,
// controller state encoding and the access-size-to-byte-count helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  // Size code 11 is treated as a word, same as 10.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, on contention the
// requester that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the core LSU and the loader onto one shared byte-addressed data
// memory, with bounds check at accept and a SETUP/STROBE/CAPTURE handshake.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [1:0]        size0,
  input  logic              sext0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        size1,
  input  logic              sext1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        mem_size,
  output logic              mem_sext,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int AW1 = ADDR_W + 1;

  logic [1:0]        req_v;
  logic [1:0]        gnt;
  logic              sel;
  logic              we_a    [2];
  logic [ADDR_W-1:0] addr_a  [2];
  logic [DATA_W-1:0] wdata_a [2];
  logic [1:0]        size_a  [2];
  logic              sext_a  [2];
  logic [2:0]        nb;
  logic [ADDR_W:0]   end_addr;
  logic              oob;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              who_q, who_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic              mem_sext_q, mem_sext_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        rd_load;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  assign req_v      = {req1, req0};
  assign we_a[0]    = we0;
  assign we_a[1]    = we1;
  assign addr_a[0]  = addr0;
  assign addr_a[1]  = addr1;
  assign wdata_a[0] = wdata0;
  assign wdata_a[1] = wdata1;
  assign size_a[0]  = size0;
  assign size_a[1]  = size1;
  assign sext_a[0]  = sext0;
  assign sext_a[1]  = sext1;

  rr_arbiter2 u_arb (
    .req  (req_v),
    .last (last_q),
    .gnt  (gnt)
  );

  assign sel      = gnt[1];
  assign nb       = nbytes(size_a[sel]);
  assign end_addr = {1'b0, addr_a[sel]} + AW1'(nb) - AW1'(1);
  assign oob      = end_addr[ADDR_W];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    who_d      = who_q;
    mem_en_d   = 1'b0;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_size_d = mem_size_q;
    mem_sext_d = mem_sext_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    rd_load    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          last_d = sel;
          who_d  = sel;
          if (oob) begin
            state_d     = ST_ERR;
            done_d[sel] = 1'b1;
            err_d[sel]  = 1'b1;
          end else begin
            // The memory bus is only reloaded for accesses that will strobe.
            state_d    = ST_SETUP;
            mem_rw_d   = we_a[sel];
            mem_addr_d = addr_a[sel];
            mem_din_d  = wdata_a[sel];
            mem_size_d = size_a[sel];
            mem_sext_d = sext_a[sel];
          end
        end
      end
      ST_SETUP: begin
        state_d  = ST_STROBE;
        mem_en_d = 1'b1;
      end
      ST_STROBE: begin
        // Read data and done land together on the edge entering CAPTURE.
        state_d       = ST_CAPTURE;
        done_d[who_q] = 1'b1;
        if (!mem_rw_q) begin
          rd_load[who_q] = 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      who_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_size_q <= 2'b00;
      mem_sext_q <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      who_q      <= who_d;
      mem_en_q   <= mem_en_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_size_q <= mem_size_d;
      mem_sext_q <= mem_sext_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    assign rdata_d[gi] = rd_load[gi] ? mem_dout : rdata_q[gi];
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q[gi] <= '0;
      end else begin
        rdata_q[gi] <= rdata_d[gi];
      end
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_size = mem_size_q;
  assign mem_sext = mem_sext_q;
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign rdata0   = rdata_q[0];
  assign rdata1   = rdata_q[1];

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: async-read byte memory model on the memory side,
// transaction-level reference model, directed table, corner sequences, random.
module tb_dmem_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, sext0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [1:0]    size0 = 2'b00;
  logic          req1 = 1'b0, we1 = 1'b0, sext1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic [1:0]    size1 = 2'b00;
  logic          done0, err0, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_rw, mem_sext;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [1:0]    mem_size;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0), .sext0(sext0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1), .sext1(sext1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_size(mem_size), .mem_sext(mem_sext), .mem_dout(mem_dout)
  );

  function automatic int tb_nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit sx);
    if (nb == 1) return sx ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
    if (nb == 2) return sx ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
    return raw;
  endfunction

  // Memory environment: little-endian bytes, asynchronous read, write on a strobed edge.
  logic [7:0]  env_mem [512];
  logic        init_mem = 1'b1;
  logic [31:0] env_raw;
  logic [8:0]  env_ia;

  always @(posedge clk) begin : env_wr
    logic [8:0] wa;
    if (init_mem) begin
      for (int i = 0; i < 512; i++) env_mem[i] <= 8'h00;
    end else if (mem_en && mem_rw) begin
      for (int i = 0; i < tb_nbytes(mem_size); i++) begin
        wa = mem_addr + 9'(i);
        env_mem[wa] <= mem_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    env_raw = 32'h0;
    env_ia  = 9'h0;
    for (int i = 0; i < 4; i++) begin
      env_ia = mem_addr + 9'(i);
      env_raw[8*i +: 8] = env_mem[env_ia];
    end
    mem_dout = extend(env_raw, tb_nbytes(mem_size), mem_sext);
  end

  // Reference model state.
  logic [7:0]  ref_mem [512];
  int          last_g;
  logic [31:0] ref_rd [2];

  int errors = 0;
  int checks = 0;
  int ntxn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_txn(input int who, input bit we, input logic [8:0] a,
                                    input logic [31:0] wd, input logic [1:0] sz, input bit sx,
                                    output bit err, output logic [31:0] rd);
    int nbv;
    logic [31:0] raw;
    logic [8:0] ia;
    nbv = tb_nbytes(sz);
    err = (int'(a) + nbv > 512);
    raw = 32'h0;
    if (!err) begin
      for (int i = 0; i < nbv; i++) begin
        ia = a + 9'(i);
        if (we) ref_mem[ia] = wd[8*i +: 8];
        else    raw[8*i +: 8] = ref_mem[ia];
      end
      if (!we) ref_rd[who] = extend(raw, nbv, sx);
    end
    last_g = who;
    rd = ref_rd[who];
  endfunction

  task automatic set_req(input int who, input bit r, input bit we, input logic [8:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit sx);
    if (who == 0) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = wd; size0 = sz; sext0 = sx;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = wd; size1 = sz; sext1 = sx;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_mem_size", 32'(mem_size), 32'd0);
    chk("rst_mem_sext", 32'(mem_sext), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_err", 32'({err1, err0}), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    last_g = 1;
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
  endtask

  // Single request from one requester, held until its done pulse.
  task automatic run_txn(input int who, input bit we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sx, input bit exp_err,
                         input logic [31:0] exp_rd);
    int done_k, en_cnt, en_k;
    bit other_bad, bus_bad, act_err, my_done, my_err, ot_act;
    logic [31:0] act_rd, my_rd;
    done_k = -1; en_cnt = 0; en_k = -1; other_bad = 0; bus_bad = 0;
    act_err = 0; act_rd = 32'h0;
    @(negedge clk);
    set_req(who, 1'b1, we, a, wd, sz, sx);
    for (int k = 1; k <= 10 && done_k < 0; k++) begin
      @(negedge clk);
      my_done = (who == 0) ? done0 : done1;
      my_err  = (who == 0) ? err0 : err1;
      my_rd   = (who == 0) ? rdata0 : rdata1;
      ot_act  = (who == 0) ? (done1 | err1) : (done0 | err0);
      if (mem_en) begin en_cnt++; en_k = k; end
      if (ot_act) other_bad = 1;
      if (!exp_err && k <= 3) begin
        if (mem_addr !== a || mem_rw !== we || mem_size !== sz || mem_sext !== sx ||
            (we && mem_din !== wd)) bus_bad = 1;
      end
      if (my_done) begin done_k = k; act_err = my_err; act_rd = my_rd; end
    end
    set_req(who, 1'b0, we, a, wd, sz, sx);
    chk("latency", 32'(done_k), exp_err ? 32'd1 : 32'd3);
    chk("err", 32'(act_err), 32'(exp_err));
    chk("rdata", act_rd, exp_rd);
    chk("mem_en_count", 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      chk("mem_en_cycle", 32'(en_k), 32'd2);
      chk("bus_stable", 32'(bus_bad), 32'd0);
    end
    chk("other_quiet", 32'(other_bad), 32'd0);
    ntxn++;
    $display("txn %0d who=%0d we=%0d addr=%h size=%0d sext=%0d wdata=%h -> done@%0d err=%0d rdata=%h",
             ntxn, who, we, a, sz, sx, wd, done_k, act_err, act_rd);
  endtask

  // Both requesters read at once; order must follow the round-robin rule.
  task automatic contend(input logic [8:0] a0, input logic [8:0] a1);
    int order [2];
    int n, first_exp;
    bit both_bad, e;
    logic [31:0] r0, r1, x0, x1;
    order[0] = -1; order[1] = -1; n = 0; both_bad = 0; r0 = 32'h0; r1 = 32'h0;
    first_exp = (last_g == 1) ? 0 : 1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, a0, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b1, 1'b0, a1, 32'h0, 2'b10, 1'b0);
    for (int k = 1; k <= 20 && n < 2; k++) begin
      @(negedge clk);
      if (done0 && done1) both_bad = 1;
      if (done0) begin order[n] = 0; n++; r0 = rdata0; req0 = 1'b0; end
      if (done1 && n < 2) begin order[n] = 1; n++; r1 = rdata1; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    if (first_exp == 0) begin
      model_txn(0, 1'b0, a0, 32'h0, 2'b10, 1'b0, e, x0);
      model_txn(1, 1'b0, a1, 32'h0, 2'b10, 1'b0, e, x1);
    end else begin
      model_txn(1, 1'b0, a1, 32'h0, 2'b10, 1'b0, e, x1);
      model_txn(0, 1'b0, a0, 32'h0, 2'b10, 1'b0, e, x0);
    end
    chk("contend_first", 32'(order[0]), 32'(first_exp));
    chk("contend_second", 32'(order[1]), 32'(1 - first_exp));
    chk("contend_rdata0", r0, x0);
    chk("contend_rdata1", r1, x1);
    chk("contend_overlap", 32'(both_bad), 32'd0);
    ntxn++;
    $display("txn %0d contention a0=%h a1=%h order=%0d,%0d rdata0=%h rdata1=%h",
             ntxn, a0, a1, order[0], order[1], r0, r1);
  endtask

  typedef struct {
    int          who;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          sext;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [14];

  initial begin
    bit e;
    logic [31:0] r;
    bit bad;
    int who, k3;
    logic [8:0] a;
    logic [1:0] sz;
    bit we, sx;
    logic [31:0] wd;

    vt[0]  = '{0, 1'b1, 9'h010, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h00000000};
    vt[1]  = '{1, 1'b0, 9'h010, 32'h00000000, 2'b00, 1'b1, 1'b0, 32'hFFFFFFEF};
    vt[2]  = '{1, 1'b0, 9'h010, 32'h00000000, 2'b01, 1'b0, 1'b0, 32'h0000BEEF};
    vt[3]  = '{0, 1'b0, 9'h012, 32'h00000000, 2'b01, 1'b1, 1'b0, 32'hFFFFDEAD};
    vt[4]  = '{0, 1'b1, 9'h1FE, 32'h55555555, 2'b10, 1'b0, 1'b1, 32'hFFFFDEAD};
    vt[5]  = '{0, 1'b1, 9'h1FE, 32'h00001234, 2'b01, 1'b0, 1'b0, 32'hFFFFDEAD};
    vt[6]  = '{1, 1'b0, 9'h1FE, 32'h00000000, 2'b01, 1'b0, 1'b0, 32'h00001234};
    vt[7]  = '{1, 1'b0, 9'h1FF, 32'h00000000, 2'b00, 1'b1, 1'b0, 32'h00000012};
    vt[8]  = '{1, 1'b1, 9'h1FF, 32'h00000080, 2'b00, 1'b0, 1'b0, 32'h00000012};
    vt[9]  = '{1, 1'b0, 9'h1FF, 32'h00000000, 2'b00, 1'b1, 1'b0, 32'hFFFFFF80};
    vt[10] = '{0, 1'b0, 9'h010, 32'h00000000, 2'b11, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[11] = '{0, 1'b0, 9'h1FF, 32'h00000000, 2'b11, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[12] = '{1, 1'b1, 9'h1FF, 32'h0000ABCD, 2'b01, 1'b0, 1'b1, 32'hFFFFFF80};
    vt[13] = '{0, 1'b0, 9'h011, 32'h00000000, 2'b00, 1'b0, 1'b0, 32'h000000BE};

    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    ref_rd[0] = 32'h0; ref_rd[1] = 32'h0; last_g = 1;
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    do_reset();

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      model_txn(vt[i].who, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].sext, e, r);
      run_txn(vt[i].who, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].sext,
              vt[i].exp_err, vt[i].exp_rd);
    end

    // Contention after reset, then after a lone requester-0 grant.
    do_reset();
    contend(9'h010, 9'h1FC);
    contend(9'h1FC, 9'h010);
    model_txn(0, 1'b0, 9'h004, 32'h0, 2'b10, 1'b0, e, r);
    run_txn(0, 1'b0, 9'h004, 32'h0, 2'b10, 1'b0, e, r);
    contend(9'h010, 9'h004);

    // Request 1 pulses while requester 0 is being served and must be ignored.
    bad = 0; k3 = 0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D, 2'b10, 1'b0);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    k3 = done0;
    r = rdata0;
    req0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done1 || err1 || mem_en) bad = 1;
    end
    model_txn(0, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0, e, wd);
    chk("drop_done0", 32'(k3), 32'd1);
    chk("drop_rdata0", r, wd);
    chk("dropped_req_ignored", 32'(bad), 32'd0);
    ntxn++;
    $display("txn %0d pulsed req1 during service: done0=%0d ignored=%0d", ntxn, k3, !bad);

    // Reset landing on the STROBE cycle of a write.
    bad = 0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 9'h040, 32'h13579BDF, 2'b10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("strobe_before_rst", 32'(mem_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_mem_en", 32'(mem_en), 32'd0);
    chk("rst_no_done", 32'({done1, done0}), 32'd0);
    rst = 1'b0;
    req0 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1 || mem_en) bad = 1;
    end
    chk("rst_quiet_after", 32'(bad), 32'd0);
    model_txn(0, 1'b1, 9'h040, 32'h13579BDF, 2'b10, 1'b0, e, r);
    last_g = 1; ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
    ntxn++;
    $display("txn %0d reset during STROBE: quiet=%0d", ntxn, !bad);
    model_txn(1, 1'b0, 9'h040, 32'h0, 2'b10, 1'b0, e, r);
    run_txn(1, 1'b0, 9'h040, 32'h0, 2'b10, 1'b0, e, r);

    // Random single-requester traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      who = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 9'($urandom_range(500, 511));
      else                           a = 9'($urandom_range(0, 511));
      model_txn(who, we, a, wd, sz, sx, e, r);
      run_txn(who, we, a, wd, sz, sx, e, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
